// File: rtl/clock_pkg.sv
// Shared definitions for the clock-setting datapath: mode encoding and field limits,
// used by the counters, the display and the set controller.
package clock_pkg;

    typedef enum logic [1:0] {
        MODE_RUN      = 2'd0,
        MODE_SET_HOUR = 2'd1,
        MODE_SET_MIN  = 2'd2,
        MODE_COMMIT   = 2'd3
    } mode_e;

    localparam logic [5:0] SEC_MAX  = 6'd59;
    localparam logic [5:0] MIN_MAX  = 6'd59;
    localparam logic [4:0] HOUR_MAX = 5'd23;

endpackage

// File: rtl/clock_field_edit.sv
// Editable copy of one time field: loads a snapshot of the live counter, then
// increments with wrap from MAX back to zero.
module clock_field_edit #(
    parameter int WIDTH = 6,
    parameter int MAX   = 59
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             capture,
    input  logic [WIDTH-1:0] capture_val,
    input  logic             inc,
    output logic [WIDTH-1:0] value
);

    localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            value <= '0;
        end else if (capture) begin
            value <= capture_val;
        end else if (inc) begin
            value <= (value == MAX_V) ? '0 : value + 1'b1;
        end
    end

endmodule

// File: rtl/clock_set_ctrl.sv
// Time-setting controller: gates the live counter enables in RUN, walks the user
// through hour/minute edits, and presets all counters with one load strobe on commit.
module clock_set_ctrl
    import clock_pkg::*;
#(
    parameter int TIMEOUT_S = 30
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick_1hz,
    input  logic       btn_mode,
    input  logic       btn_inc,
    input  logic [5:0] sec_q,
    input  logic [5:0] min_q,
    input  logic [4:0] hour_q,
    output logic       sec_en,
    output logic       min_en,
    output logic       hour_en,
    output logic       load,
    output logic [5:0] sec_d,
    output logic [5:0] min_d,
    output logic [4:0] hour_d,
    output logic [1:0] mode,
    output logic       blink
);

    localparam logic [1:0] RUN      = MODE_RUN;
    localparam logic [1:0] SET_HOUR = MODE_SET_HOUR;
    localparam logic [1:0] SET_MIN  = MODE_SET_MIN;
    localparam logic [1:0] COMMIT   = MODE_COMMIT;

    localparam int TW = $clog2(TIMEOUT_S + 1);
    localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_S - 1);

    logic [1:0]    state;
    logic [1:0]    next_state;
    logic [TW-1:0] timeout;
    logic          in_set;
    logic          next_in_set;
    logic          timeout_hit;
    logic          capture;
    logic          inc_hour;
    logic          inc_min;
    logic [4:0]    edit_hour;
    logic [5:0]    edit_min;

    assign in_set      = (state == SET_HOUR) || (state == SET_MIN);
    assign next_in_set = (next_state == SET_HOUR) || (next_state == SET_MIN);
    assign timeout_hit = in_set && !btn_mode && !btn_inc && tick_1hz && (timeout == TIMEOUT_LAST);

    // btn_mode has priority, so a simultaneous btn_inc never reaches the edit registers
    assign capture  = (state == RUN) && btn_mode;
    assign inc_hour = (state == SET_HOUR) && btn_inc && !btn_mode;
    assign inc_min  = (state == SET_MIN) && btn_inc && !btn_mode;

    always_comb begin
        next_state = state;
        case (state)
            RUN: begin
                if (btn_mode) next_state = SET_HOUR;
            end
            SET_HOUR: begin
                if (btn_mode)         next_state = SET_MIN;
                else if (timeout_hit) next_state = RUN;
            end
            SET_MIN: begin
                if (btn_mode)         next_state = COMMIT;
                else if (timeout_hit) next_state = RUN;
            end
            default: next_state = RUN;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= RUN;
        end else begin
            state <= next_state;
        end
    end

    // Idle seconds since the last press; held at zero outside the edit states
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            timeout <= '0;
        end else if (!next_in_set || btn_mode || btn_inc) begin
            timeout <= '0;
        end else if (tick_1hz) begin
            timeout <= timeout + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            blink <= 1'b0;
        end else if (!next_in_set || inc_hour || inc_min) begin
            blink <= 1'b0;
        end else if (tick_1hz) begin
            blink <= ~blink;
        end
    end

    clock_field_edit #(
        .WIDTH (5),
        .MAX   (int'(HOUR_MAX))
    ) u_hour_edit (
        .clk         (clk),
        .rst         (rst),
        .capture     (capture),
        .capture_val (hour_q),
        .inc         (inc_hour),
        .value       (edit_hour)
    );

    clock_field_edit #(
        .WIDTH (6),
        .MAX   (int'(MIN_MAX))
    ) u_min_edit (
        .clk         (clk),
        .rst         (rst),
        .capture     (capture),
        .capture_val (min_q),
        .inc         (inc_min),
        .value       (edit_min)
    );

    assign sec_en  = (state == RUN) && tick_1hz;
    assign min_en  = sec_en && (sec_q == SEC_MAX);
    assign hour_en = min_en && (min_q == MIN_MAX);

    assign mode   = state;
    assign load   = (state == COMMIT);
    assign hour_d = load ? edit_hour : 5'd0;
    assign min_d  = load ? edit_min : 6'd0;
    assign sec_d  = 6'd0;

endmodule

// File: tb/tb_clock_set_ctrl.sv
// Directed bench for clock_set_ctrl: expectations are queued as stimulus is applied
// and popped against the outputs once they settle.
module tb_clock_set_ctrl;

    localparam int TO = 30;

    localparam logic [23:0] M_BLINK = 24'h000001;
    localparam logic [23:0] M_EN    = 24'h00000E;
    localparam logic [23:0] M_DATA  = 24'h1FFFF0;
    localparam logic [23:0] M_LOAD  = 24'h200000;
    localparam logic [23:0] M_MODE  = 24'hC00000;
    localparam logic [23:0] M_ALL   = 24'hFFFFFF;
    localparam logic [23:0] M_REG   = M_MODE | M_LOAD | M_DATA | M_BLINK;

    typedef struct {
        string       tag;
        logic [23:0] exp;
        logic [23:0] mask;
    } exp_t;

    logic       clk;
    logic       rst;
    logic       tick_1hz;
    logic       btn_mode;
    logic       btn_inc;
    logic [5:0] sec_q;
    logic [5:0] min_q;
    logic [4:0] hour_q;
    logic       sec_en;
    logic       min_en;
    logic       hour_en;
    logic       load;
    logic [5:0] sec_d;
    logic [5:0] min_d;
    logic [4:0] hour_d;
    logic [1:0] mode;
    logic       blink;

    exp_t scoreboard[$];
    int   checks = 0;
    int   errors = 0;

    clock_set_ctrl #(.TIMEOUT_S(TO)) dut (
        .clk      (clk),
        .rst      (rst),
        .tick_1hz (tick_1hz),
        .btn_mode (btn_mode),
        .btn_inc  (btn_inc),
        .sec_q    (sec_q),
        .min_q    (min_q),
        .hour_q   (hour_q),
        .sec_en   (sec_en),
        .min_en   (min_en),
        .hour_en  (hour_en),
        .load     (load),
        .sec_d    (sec_d),
        .min_d    (min_d),
        .hour_d   (hour_d),
        .mode     (mode),
        .blink    (blink)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [23:0] mk(input logic [1:0] m, input logic ld, input logic [4:0] hd,
                                       input logic [5:0] md, input logic [5:0] sd,
                                       input logic [2:0] en, input logic bl);
        return {m, ld, hd, md, sd, en, bl};
    endfunction

    task automatic pushExp(input string tag, input logic [23:0] exp, input logic [23:0] mask);
        exp_t e;
        e.tag  = tag;
        e.exp  = exp;
        e.mask = mask;
        scoreboard.push_back(e);
    endtask

    task automatic checkOutput();
        exp_t        e;
        logic [23:0] obs;
        while (scoreboard.size() > 0) begin
            e   = scoreboard.pop_front();
            obs = {mode, load, hour_d, min_d, sec_d, sec_en, min_en, hour_en, blink};
            checks++;
            assert ((obs & e.mask) === (e.exp & e.mask)) else begin
                errors++;
                $error("[TB] FAIL %s observed=%h expected=%h", e.tag, obs & e.mask, e.exp & e.mask);
            end
        end
    endtask

    // One clock with the given one-cycle pulses; returns 1 time unit after the edge
    task automatic applyStimulus(input logic t, input logic m, input logic i);
        tick_1hz = t;
        btn_mode = m;
        btn_inc  = i;
        @(posedge clk);
        #1;
        tick_1hz = 1'b0;
        btn_mode = 1'b0;
        btn_inc  = 1'b0;
    endtask

    initial begin
        rst      = 1'b1;
        tick_1hz = 1'b0;
        btn_mode = 1'b0;
        btn_inc  = 1'b0;
        sec_q    = 6'd0;
        min_q    = 6'd0;
        hour_q   = 5'd0;

        #2;
        pushExp("reset_state", mk(2'd0, 1'b0, 5'd0, 6'd0, 6'd0, 3'b000, 1'b0), M_ALL);
        checkOutput();
        tick_1hz = 1'b1;
        #1;
        pushExp("reset_enables", mk(2'd0, 1'b0, 5'd0, 6'd0, 6'd0, 3'b100, 1'b0), M_ALL);
        checkOutput();
        tick_1hz = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        applyStimulus(1'b0, 1'b0, 1'b0);

        // Live-counter enable chain
        sec_q = 6'd59; min_q = 6'd59; hour_q = 5'd23; tick_1hz = 1'b1;
        #1;
        pushExp("rollover_all", mk(2'd0, 1'b0, 5'd0, 6'd0, 6'd0, 3'b111, 1'b0), M_EN);
        checkOutput();
        sec_q = 6'd58;
        #1;
        pushExp("rollover_sec_only", mk(2'd0, 1'b0, 5'd0, 6'd0, 6'd0, 3'b100, 1'b0), M_EN);
        checkOutput();
        sec_q = 6'd59; min_q = 6'd58;
        #1;
        pushExp("rollover_sec_min", mk(2'd0, 1'b0, 5'd0, 6'd0, 6'd0, 3'b110, 1'b0), M_EN);
        checkOutput();
        tick_1hz = 1'b0;
        #1;
        pushExp("no_tick_no_en", mk(2'd0, 1'b0, 5'd0, 6'd0, 6'd0, 3'b000, 1'b0), M_EN);
        checkOutput();
        applyStimulus(1'b1, 1'b0, 1'b0);
        pushExp("run_tick_no_blink", mk(2'd0, 1'b0, 5'd0, 6'd0, 6'd0, 3'b000, 1'b0), M_REG);
        checkOutput();
        applyStimulus(1'b0, 1'b0, 1'b1);
        pushExp("run_inc_ignored", mk(2'd0, 1'b0, 5'd0, 6'd0, 6'd0, 3'b000, 1'b0), M_REG);
        checkOutput();

        // Full set with both fields wrapping to zero
        sec_q = 6'd17; min_q = 6'd5; hour_q = 5'd10;
        applyStimulus(1'b0, 1'b1, 1'b0);
        pushExp("enter_set_hour", mk(2'd1, 1'b0, 5'd0, 6'd0, 6'd0, 3'b000, 1'b0), M_REG);
        checkOutput();
        sec_q = 6'd59; min_q = 6'd59; tick_1hz = 1'b1;
        #1;
        pushExp("set_hour_en_gated", mk(2'd1, 1'b0, 5'd0, 6'd0, 6'd0, 3'b000, 1'b0), M_EN);
        checkOutput();
        tick_1hz = 1'b0;
        for (int k = 0; k < 13; k++) applyStimulus(1'b0, 1'b0, 1'b1);
        applyStimulus(1'b1, 1'b0, 1'b0);
        pushExp("blink_toggles", mk(2'd1, 1'b0, 5'd0, 6'd0, 6'd0, 3'b000, 1'b1), M_REG);
        checkOutput();
        applyStimulus(1'b0, 1'b0, 1'b1);
        pushExp("inc_clears_blink", mk(2'd1, 1'b0, 5'd0, 6'd0, 6'd0, 3'b000, 1'b0), M_REG);
        checkOutput();
        applyStimulus(1'b0, 1'b1, 1'b0);
        pushExp("enter_set_min", mk(2'd2, 1'b0, 5'd0, 6'd0, 6'd0, 3'b000, 1'b0), M_REG);
        checkOutput();
        for (int k = 0; k < 55; k++) applyStimulus(1'b0, 1'b0, 1'b1);
        applyStimulus(1'b0, 1'b1, 1'b0);
        pushExp("commit_wrap", mk(2'd3, 1'b1, 5'd0, 6'd0, 6'd0, 3'b000, 1'b0), M_REG);
        checkOutput();
        applyStimulus(1'b0, 1'b1, 1'b1);
        pushExp("commit_one_cycle", mk(2'd0, 1'b0, 5'd0, 6'd0, 6'd0, 3'b000, 1'b0), M_REG);
        checkOutput();

        // Simultaneous press: mode wins, hour keeps its edited value
        sec_q = 6'd0; min_q = 6'd30; hour_q = 5'd22;
        applyStimulus(1'b0, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b1);
        applyStimulus(1'b0, 1'b1, 1'b1);
        pushExp("simul_press_mode", mk(2'd2, 1'b0, 5'd0, 6'd0, 6'd0, 3'b000, 1'b0), M_REG);
        checkOutput();
        applyStimulus(1'b0, 1'b1, 1'b0);
        pushExp("simul_press_commit", mk(2'd3, 1'b1, 5'd23, 6'd30, 6'd0, 3'b000, 1'b0), M_REG);
        checkOutput();
        applyStimulus(1'b0, 1'b0, 1'b0);

        // Timeout with no presses
        min_q = 6'd4; hour_q = 5'd3;
        applyStimulus(1'b0, 1'b1, 1'b0);
        for (int k = 1; k < TO; k++) begin
            applyStimulus(1'b1, 1'b0, 1'b0);
            pushExp($sformatf("timeout_wait_%0d", k), mk(2'd1, 1'b0, 5'd0, 6'd0, 6'd0, 3'b000, 1'b0),
                    M_MODE | M_LOAD);
            checkOutput();
        end
        applyStimulus(1'b1, 1'b0, 1'b0);
        pushExp("timeout_return", mk(2'd0, 1'b0, 5'd0, 6'd0, 6'd0, 3'b000, 1'b0), M_REG);
        checkOutput();
        applyStimulus(1'b0, 1'b0, 1'b0);
        pushExp("timeout_no_load", mk(2'd0, 1'b0, 5'd0, 6'd0, 6'd0, 3'b000, 1'b0), M_REG);
        checkOutput();

        // Timeout restarted by a press at tick TO-1
        applyStimulus(1'b0, 1'b1, 1'b0);
        for (int k = 1; k < TO; k++) applyStimulus(1'b1, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b1);
        for (int k = 1; k < TO; k++) applyStimulus(1'b1, 1'b0, 1'b0);
        pushExp("timeout_restart_hold", mk(2'd1, 1'b0, 5'd0, 6'd0, 6'd0, 3'b000, 1'b0), M_MODE | M_LOAD);
        checkOutput();
        applyStimulus(1'b1, 1'b0, 1'b0);
        pushExp("timeout_restart_return", mk(2'd0, 1'b0, 5'd0, 6'd0, 6'd0, 3'b000, 1'b0), M_REG);
        checkOutput();

        // Reset in the middle of a minute edit
        min_q = 6'd8; hour_q = 5'd7;
        applyStimulus(1'b0, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b0);
        for (int k = 0; k < 3; k++) applyStimulus(1'b0, 1'b0, 1'b1);
        applyStimulus(1'b1, 1'b0, 1'b0);
        pushExp("pre_reset_blink", mk(2'd2, 1'b0, 5'd0, 6'd0, 6'd0, 3'b000, 1'b1), M_REG);
        checkOutput();
        rst = 1'b1;
        #1;
        pushExp("reset_mid_edit", mk(2'd0, 1'b0, 5'd0, 6'd0, 6'd0, 3'b000, 1'b0), M_REG);
        checkOutput();
        @(negedge clk);
        rst = 1'b0;
        applyStimulus(1'b0, 1'b0, 1'b0);
        pushExp("post_reset_no_load", mk(2'd0, 1'b0, 5'd0, 6'd0, 6'd0, 3'b000, 1'b0), M_REG);
        checkOutput();
        min_q = 6'd20; hour_q = 5'd15;
        applyStimulus(1'b0, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b0);
        pushExp("fresh_capture", mk(2'd3, 1'b1, 5'd15, 6'd20, 6'd0, 3'b000, 1'b0), M_REG);
        checkOutput();
        applyStimulus(1'b0, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
